// File: rtl/mapper_pkg.sv
// Shared constants, state and error encodings for the mapper init sequencer.
// MAPPER_GPIO_EN adds the IOCTL/IOSCN registers to the write phase.
package mapper_pkg;

  localparam logic [7:0] ADDR_ACK   = 8'h5A;
  localparam logic [7:0] ADDR_NAK   = 8'hA5;
  localparam logic [7:0] ADDR_LAO   = 8'hC0;
  localparam logic [7:0] ADDR_RAMB  = 8'hC1;
  localparam logic [7:0] ADDR_ROMB0 = 8'hC2;
  localparam logic [7:0] ADDR_ROMB1 = 8'hC3;
  localparam logic [7:0] ADDR_IOCTL = 8'hCC;
  localparam logic [7:0] ADDR_IOSCN = 8'hCD;
  localparam logic [7:0] ADDR_IDLE  = 8'hFF;

  localparam int                  SYNC_LEN  = 18;
  localparam logic [SYNC_LEN-1:0] SYNC_WORD = 18'h05140;

`ifdef MAPPER_GPIO_EN
  localparam int NUM_WR = 6;
`else
  localparam int NUM_WR = 4;
`endif
  // GPIO registers are write-only, so readback always covers C0..C3
  localparam int NUM_RB = 4;
  localparam int IDX_W  = $clog2(NUM_WR);

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_UNLK_ACK  = 4'd1,
    ST_UNLK_NAK  = 4'd2,
    ST_SYNC      = 4'd3,
    ST_WR_SETUP  = 4'd4,
    ST_WR_STROBE = 4'd5,
    ST_WR_HOLD   = 4'd6,
    ST_RD_ADDR   = 4'd7,
    ST_RD_SAMPLE = 4'd8,
    ST_FIN       = 4'd9
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_SYNC     = 2'd1,
    ERR_READBACK = 2'd2
  } err_e;

  function automatic logic [7:0] reg_addr(input logic [2:0] idx);
    case (idx)
      3'd0:    return ADDR_LAO;
      3'd1:    return ADDR_RAMB;
      3'd2:    return ADDR_ROMB0;
      3'd3:    return ADDR_ROMB1;
      3'd4:    return ADDR_IOCTL;
      3'd5:    return ADDR_IOSCN;
      default: return ADDR_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/mapper_init_seq_if.sv
// Mapper-side bus: register address/data, strobes and the serial sync output.
interface mapper_init_seq_if;
    logic [7:0] ADDR;
    logic [7:0] DQ_O;
    logic       DQ_OE;
    logic [7:0] DQ_I;
    logic       CEn;
    logic       SSn;
    logic       WEn;
    logic       OEn;
    logic       SO_I;

    modport master (
        output ADDR, DQ_O, DQ_OE, CEn, SSn, WEn, OEn,
        input  DQ_I, SO_I
    );

    modport slave (
        input  ADDR, DQ_O, DQ_OE, CEn, SSn, WEn, OEn,
        output DQ_I, SO_I
    );
endinterface

// File: rtl/mapper_sync_capture.sv
// Collects the 18-bit LSB-first sync word from the mapper serial output.
module mapper_sync_capture
    import mapper_pkg::*;
(
    input  logic CLK,
    input  logic RSTn,
    input  logic en,
    input  logic so,
    output logic match,
    output logic valid
);
    logic [SYNC_LEN-1:0] sr;
    logic [4:0]          cnt;
    logic [SYNC_LEN-1:0] word;

    // Word including the bit arriving this edge, so the decision lands on the 18th sample.
    assign word  = {so, sr[SYNC_LEN-1:1]};
    assign valid = en && (cnt == 5'(SYNC_LEN - 1));
    assign match = valid && (word == SYNC_WORD);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            sr  <= '0;
            cnt <= '0;
        end else if (!en) begin
            sr  <= '0;
            cnt <= '0;
        end else begin
            sr  <= word;
            cnt <= cnt + 5'd1;
        end
    end
endmodule

// File: rtl/mapper_init_seq.sv
// Mapper init sequencer: unlock, sync check, bank register writes and optional readback.
// Define MAPPER_GPIO_EN to also program IOCTL (CC) and IOSCN (CD) after the bank registers.
module mapper_init_seq
    import mapper_pkg::*;
#(
    parameter int VERIFY_RB = 1
) (
    input  logic               CLK,
    input  logic               RSTn,
    input  logic               start,
    input  logic [7:0]         cfg_lao,
    input  logic [7:0]         cfg_ramb,
    input  logic [7:0]         cfg_romb0,
    input  logic [7:0]         cfg_romb1,
`ifdef MAPPER_GPIO_EN
    input  logic [3:0]         cfg_ioctl,
    input  logic [3:0]         cfg_ioscn,
`endif
    output logic               busy,
    output logic               done,
    output logic [1:0]         err_code,
    mapper_init_seq_if.master  bus
);
    localparam logic [IDX_W-1:0] LAST_WR = IDX_W'(NUM_WR - 1);
    localparam logic [IDX_W-1:0] LAST_RB = IDX_W'(NUM_RB - 1);

    state_e                     state;
    err_e                       err_q;
    logic [IDX_W-1:0]           idx;
    logic                       armed;
    logic [NUM_WR-1:0][7:0]     cfg_q;
    logic                       sync_match;
    logic                       sync_valid;

    assign err_code = err_q;

    mapper_sync_capture u_sync (
        .CLK   (CLK),
        .RSTn  (RSTn),
        .en    (state == ST_SYNC),
        .so    (bus.SO_I),
        .match (sync_match),
        .valid (sync_valid)
    );

    // armed stays low for the first edge after reset release so a start there is dropped.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state <= ST_IDLE;
            err_q <= ERR_NONE;
            idx   <= '0;
            armed <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            cfg_q <= '0;
        end else begin
            armed <= 1'b1;
            case (state)
                ST_IDLE: if (start && armed) begin
                    state    <= ST_UNLK_ACK;
                    busy     <= 1'b1;
                    done     <= 1'b0;
                    err_q    <= ERR_NONE;
                    cfg_q[0] <= cfg_lao;
                    cfg_q[1] <= cfg_ramb;
                    cfg_q[2] <= cfg_romb0;
                    cfg_q[3] <= cfg_romb1;
`ifdef MAPPER_GPIO_EN
                    cfg_q[4] <= {4'h0, cfg_ioctl};
                    cfg_q[5] <= {4'h0, cfg_ioscn};
`endif
                end
                ST_UNLK_ACK: state <= ST_UNLK_NAK;
                ST_UNLK_NAK: state <= ST_SYNC;
                ST_SYNC: if (sync_valid) begin
                    if (sync_match) begin
                        state <= ST_WR_SETUP;
                        idx   <= '0;
                    end else begin
                        state <= ST_FIN;
                        err_q <= ERR_SYNC;
                    end
                end
                ST_WR_SETUP:  state <= ST_WR_STROBE;
                ST_WR_STROBE: state <= ST_WR_HOLD;
                ST_WR_HOLD: if (idx == LAST_WR) begin
                    idx   <= '0;
                    state <= (VERIFY_RB != 0) ? ST_RD_ADDR : ST_FIN;
                end else begin
                    idx   <= idx + 1'b1;
                    state <= ST_WR_SETUP;
                end
                ST_RD_ADDR: state <= ST_RD_SAMPLE;
                ST_RD_SAMPLE: if (bus.DQ_I != cfg_q[idx]) begin
                    err_q <= ERR_READBACK;
                    state <= ST_FIN;
                end else if (idx == LAST_RB) begin
                    state <= ST_FIN;
                end else begin
                    idx   <= idx + 1'b1;
                    state <= ST_RD_ADDR;
                end
                ST_FIN: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Register accesses use SSn with CEn held high so ROM/RAM never see an enable.
    always_comb begin
        bus.ADDR  = ADDR_IDLE;
        bus.DQ_O  = '0;
        bus.DQ_OE = 1'b0;
        bus.CEn   = 1'b1;
        bus.SSn   = 1'b1;
        bus.WEn   = 1'b1;
        bus.OEn   = 1'b1;
        case (state)
            ST_UNLK_ACK: bus.ADDR = ADDR_ACK;
            ST_UNLK_NAK: bus.ADDR = ADDR_NAK;
            ST_WR_SETUP, ST_WR_STROBE, ST_WR_HOLD: begin
                bus.ADDR  = reg_addr(3'(idx));
                bus.DQ_O  = cfg_q[idx];
                bus.DQ_OE = 1'b1;
                bus.SSn   = 1'b0;
                bus.WEn   = (state != ST_WR_STROBE);
            end
            ST_RD_ADDR, ST_RD_SAMPLE: begin
                bus.ADDR = reg_addr(3'(idx));
                bus.SSn  = 1'b0;
                bus.OEn  = 1'b0;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mapper_init_seq.sv
// Directed bench for mapper_init_seq with a behavioural mapper model on the bus.
module tb_mapper_init_seq;
    import mapper_pkg::*;

`ifdef MAPPER_GPIO_EN
    localparam int GX = 6;
    localparam int GW = 2;
`else
    localparam int GX = 0;
    localparam int GW = 0;
`endif

    logic       CLK = 1'b0;
    logic       RSTn = 1'b0;
    logic       start = 1'b0;
    logic [7:0] cfg_lao = '0, cfg_ramb = '0, cfg_romb0 = '0, cfg_romb1 = '0;
    logic [3:0] cfg_ioctl = 4'h5, cfg_ioscn = 4'hA;
    logic       busy, done;
    logic [1:0] err_code;

    mapper_init_seq_if bus ();

    mapper_init_seq #(.VERIFY_RB(1)) dut (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .start     (start),
        .cfg_lao   (cfg_lao),
        .cfg_ramb  (cfg_ramb),
        .cfg_romb0 (cfg_romb0),
        .cfg_romb1 (cfg_romb1),
`ifdef MAPPER_GPIO_EN
        .cfg_ioctl (cfg_ioctl),
        .cfg_ioscn (cfg_ioscn),
`endif
        .busy      (busy),
        .done      (done),
        .err_code  (err_code),
        .bus       (bus)
    );

    always #5 CLK = ~CLK;

    // ---------------- mapper model and bus monitor ----------------
    logic [7:0]  regs [256];
    logic [17:0] sw = 18'h05140;
    logic        so_bad = 1'b0, bad_c2 = 1'b0, wen_prev = 1'b1, so_drv = 1'b0;
    int          sbit = 18;
    int          n_ack, n_nak, nwr, rdc, c3, viol;
    logic [7:0]  wr_addr [8];
    logic [7:0]  wr_dat  [8];

    assign bus.SO_I = so_drv;
    assign bus.DQ_I = (!bus.OEn && !bus.SSn)
                      ? ((bad_c2 && bus.ADDR == 8'hC2) ? 8'hFF : regs[bus.ADDR]) : 8'h00;

    always @(negedge CLK) begin
        if (bus.ADDR == 8'hA5) begin
            sbit = 0;
            so_drv = so_bad;
        end else if (sbit < 18) begin
            so_drv = so_bad ? 1'b1 : sw[sbit];
            sbit++;
        end else begin
            so_drv = so_bad;
        end
    end

    always @(negedge CLK) begin
        if (bus.DQ_OE && !bus.OEn) viol++;
        if (!bus.CEn) viol++;
        if (bus.ADDR == 8'h5A) n_ack++;
        if (bus.ADDR == 8'hA5) n_nak++;
        if (!bus.WEn) begin
            if (nwr < 8) begin
                wr_addr[nwr] = bus.ADDR;
                wr_dat[nwr]  = bus.DQ_O;
            end
            nwr++;
        end
        if (!bus.OEn && !bus.SSn) begin
            rdc++;
            if (bus.ADDR == 8'hC3) c3++;
        end
        if (!wen_prev && bus.WEn && !bus.SSn && bus.DQ_OE) regs[bus.ADDR] = bus.DQ_O;
        wen_prev = bus.WEn;
    end

    // ---------------- checking ----------------
    int checks = 0, errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] lao, ramb, romb0, romb1;
        logic       so_bad, bad_c2;
        logic [1:0] err;
        int         lat, nwr, rdc, c3;
    } vec_t;
    vec_t vt [4];

    task automatic clear_model();
        for (int a = 0; a < 256; a++) regs[a] = 8'h00;
        n_ack = 0; n_nak = 0; nwr = 0; rdc = 0; c3 = 0;
    endtask

    task automatic run_vec(input int v, input int restart_at);
        int n;
        logic [7:0] ea [6];
        logic [7:0] ed [6];
        ea[0] = 8'hC0; ea[1] = 8'hC1; ea[2] = 8'hC2; ea[3] = 8'hC3; ea[4] = 8'hCC; ea[5] = 8'hCD;
        ed[0] = vt[v].lao; ed[1] = vt[v].ramb; ed[2] = vt[v].romb0; ed[3] = vt[v].romb1;
        ed[4] = 8'h05; ed[5] = 8'h0A;
        @(negedge CLK);
        cfg_lao = vt[v].lao; cfg_ramb = vt[v].ramb; cfg_romb0 = vt[v].romb0; cfg_romb1 = vt[v].romb1;
        so_bad = vt[v].so_bad; bad_c2 = vt[v].bad_c2;
        clear_model();
        start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        n = 1;
        check($sformatf("busy_on_v%0d", v), busy, 1);
        check($sformatf("done_clr_v%0d", v), done, 0);
        while (!done && n < 200) begin
            if (n == restart_at) start = 1'b1;
            @(posedge CLK); #1;
            start = 1'b0;
            n++;
        end
        check($sformatf("latency_v%0d", v), n, vt[v].lat);
        check($sformatf("err_v%0d", v), err_code, vt[v].err);
        check($sformatf("busy_off_v%0d", v), busy, 0);
        check($sformatf("ack_cycles_v%0d", v), n_ack, 1);
        check($sformatf("nak_cycles_v%0d", v), n_nak, 1);
        check($sformatf("write_strobes_v%0d", v), nwr, vt[v].nwr);
        check($sformatf("read_cycles_v%0d", v), rdc, vt[v].rdc);
        check($sformatf("c3_reads_v%0d", v), c3, vt[v].c3);
        for (int k = 0; k < vt[v].nwr && k < 6; k++) begin
            check($sformatf("wr_addr_v%0d_%0d", v, k), wr_addr[k], ea[k]);
            check($sformatf("wr_data_v%0d_%0d", v, k), wr_dat[k], ed[k]);
            check($sformatf("reg_v%0d_%0d", v, k), regs[ea[k]], ed[k]);
        end
    endtask

    initial begin
        int w;
        vt[0] = '{8'h01, 8'h02, 8'h03, 8'h04, 1'b0, 1'b0, 2'd0, 42 + GX, 4 + GW, 8, 2};
        vt[1] = '{8'h01, 8'h02, 8'h03, 8'h04, 1'b1, 1'b0, 2'd1, 22,      0,      0, 0};
        vt[2] = '{8'h11, 8'h22, 8'h33, 8'h44, 1'b0, 1'b1, 2'd2, 40 + GX, 4 + GW, 6, 0};
        vt[3] = '{8'hA5, 8'h5A, 8'hFF, 8'h00, 1'b0, 1'b0, 2'd0, 42 + GX, 4 + GW, 8, 2};
        clear_model();
        viol = 0;

        // reset state
        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err_code, 0);
        check("rst_addr", bus.ADDR, 8'hFF);
        check("rst_strobes", {bus.CEn, bus.SSn, bus.WEn, bus.OEn, bus.DQ_OE}, 5'b11110);

        // start coincident with reset release is dropped
        @(negedge CLK); @(negedge CLK);
        RSTn = 1'b1; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("start_at_release", busy, 0);
        check("start_at_release_ack", n_ack, 0);

        for (int v = 0; v < 4; v++) run_vec(v, 0);

        // start while busy must not restart the sequence
        run_vec(0, 10);

        // reset pulse in the C1 write strobe
        @(negedge CLK);
        cfg_lao = 8'h01; cfg_ramb = 8'h02; cfg_romb0 = 8'h03; cfg_romb1 = 8'h04;
        so_bad = 1'b0; bad_c2 = 1'b0;
        clear_model();
        start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        w = 0;
        while (!(bus.ADDR == 8'hC1 && !bus.WEn) && w < 100) begin
            @(posedge CLK); #1;
            w++;
        end
        check("found_c1_strobe", w < 100, 1);
        RSTn = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_addr", bus.ADDR, 8'hFF);
        check("mid_rst_strobes", {bus.CEn, bus.SSn, bus.WEn, bus.OEn, bus.DQ_OE}, 5'b11110);
        nwr = 0;
        @(negedge CLK); @(negedge CLK);
        RSTn = 1'b1;
        repeat (5) @(posedge CLK);
        #1;
        check("post_rst_no_strobe", nwr, 0);
        check("post_rst_idle", {busy, done}, 2'b00);
        run_vec(0, 0);

`ifdef MAPPER_GPIO_EN
        check("gpio_cc", regs[8'hCC], 8'h05);
        check("gpio_cd", regs[8'hCD], 8'h0A);
`endif
        check("bus_rule_violations", viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
